btn_deb_multi: RTL and testbench



---
 rtl/btn_deb_multi.sv | 122 ++++++++++++
 tb/tb_btn_deb_multi.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_deb_multi.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, tick-sampled
// N-consecutive debounce, press/release strobes and a one-shot long-press strobe.
module btn_deb_multi #(
   parameter int BTN_WIDTH  = 8,
   parameter int TICK_DIV   = 250000,
   parameter int STABLE_CNT = 4,
   parameter int LONG_TICKS = 200,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BTN_WIDTH-1:0] btn_in,
   output logic [BTN_WIDTH-1:0] btn_deb,
   output logic [BTN_WIDTH-1:0] btn_press,
   output logic [BTN_WIDTH-1:0] btn_release,
   output logic [BTN_WIDTH-1:0] btn_long
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [AW-1:0] AGREE_LAST = AW'(STABLE_CNT - 1);
   localparam logic [BTN_WIDTH-1:0] REL_LVL = (ACTIVE_LOW != 0) ? {BTN_WIDTH{1'b1}} : {BTN_WIDTH{1'b0}};

   logic [BTN_WIDTH-1:0] sync_p0;
   logic [BTN_WIDTH-1:0] sync_p1;
   logic [BTN_WIDTH-1:0] lvl;
   logic [TW-1:0]        tick_cnt;
   logic                 tick;
   logic [AW-1:0]        agree_cnt [BTN_WIDTH];

   // stage p0/p1: synchroniser, preloaded with the released pin level
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= REL_LVL;
         sync_p1 <= REL_LVL;
      end else begin
         sync_p0 <= btn_in;
         sync_p1 <= sync_p0;
      end
   end

   // lvl is 1 for "pressed" whatever the pin polarity
   assign lvl = sync_p1 ^ REL_LVL;

   // shared sample tick
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   // debounce: a new level is accepted after STABLE_CNT consecutive differing samples
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_deb     <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         for (int i = 0; i < BTN_WIDTH; i++) begin
            agree_cnt[i] <= '0;
         end
      end else begin
         btn_press   <= '0;
         btn_release <= '0;
         if (tick) begin
            for (int i = 0; i < BTN_WIDTH; i++) begin
               if (lvl[i] == btn_deb[i]) begin
                  agree_cnt[i] <= '0;
               end else if (agree_cnt[i] == AGREE_LAST) begin
                  agree_cnt[i]   <= '0;
                  btn_deb[i]     <= lvl[i];
                  btn_press[i]   <= lvl[i];
                  btn_release[i] <= ~lvl[i];
               end else begin
                  agree_cnt[i] <= agree_cnt[i] + 1'b1;
               end
            end
         end
      end
   end

   // long press: hold counter saturates so the strobe fires once per press
   generate
      if (LONG_TICKS > 0) begin : g_long
         localparam int HW = $clog2(LONG_TICKS + 1);
         localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
         localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

         logic [HW-1:0] hold_cnt [BTN_WIDTH];

         always_ff @(posedge clk) begin
            if (rst) begin
               btn_long <= '0;
               for (int i = 0; i < BTN_WIDTH; i++) begin
                  hold_cnt[i] <= '0;
               end
            end else begin
               btn_long <= '0;
               for (int i = 0; i < BTN_WIDTH; i++) begin
                  if (!btn_deb[i]) begin
                     hold_cnt[i] <= '0;
                  end else if (tick && (hold_cnt[i] != HOLD_MAX)) begin
                     hold_cnt[i] <= hold_cnt[i] + 1'b1;
                     if (hold_cnt[i] == HOLD_LAST) begin
                        btn_long[i] <= 1'b1;
                     end
                  end
               end
            end
         end
      end else begin : g_nolong
         assign btn_long = '0;
      end
   endgenerate

endmodule

// File: tb/tb_btn_deb_multi.sv
// Bench for btn_deb_multi: directed scenarios plus random pin activity, each
// cycle compared against a tick/run-length reference model.
module tb_btn_deb_multi;

   localparam int BW = 2;
   localparam int TD = 4;
   localparam int SC = 3;
   localparam int LT = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [BW-1:0] btn_in = '1;
   logic [BW-1:0] btn_deb, btn_press, btn_release, btn_long;

   int n_vec = 0;
   int n_bad = 0;

   btn_deb_multi #(
      .BTN_WIDTH(BW), .TICK_DIV(TD), .STABLE_CNT(SC), .LONG_TICKS(LT), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .btn_deb(btn_deb),
      .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long)
   );

   always #5 clk = ~clk;

   // Reference model: pin seen two edges late, sample every TD-th cycle,
   // count consecutive disagreeing samples and ticks spent pressed.
   int          m_cyc;
   logic [BW-1:0] m_p1, m_p2, m_s;
   logic [BW-1:0] m_deb, m_press, m_rel, m_long;
   int          m_run [BW];
   int          m_held [BW];
   bit          m_tk;

   always @(posedge clk) begin
      if (rst) begin
         m_cyc = 0; m_p1 = '1; m_p2 = '1;
         m_deb = '0; m_press = '0; m_rel = '0; m_long = '0;
         for (int i = 0; i < BW; i++) begin m_run[i] = 0; m_held[i] = 0; end
      end else begin
         m_s  = ~m_p2;
         m_tk = ((m_cyc % TD) == TD - 1);
         m_cyc++;
         m_p2 = m_p1;
         m_p1 = btn_in;
         m_press = '0; m_rel = '0; m_long = '0;
         for (int i = 0; i < BW; i++) begin
            if (!m_deb[i]) m_held[i] = 0;
            else if (m_tk && m_held[i] < LT) begin
               m_held[i]++;
               if (m_held[i] == LT) m_long[i] = 1'b1;
            end
            if (m_tk) begin
               if (m_s[i] == m_deb[i]) m_run[i] = 0;
               else begin
                  m_run[i]++;
                  if (m_run[i] == SC) begin
                     m_deb[i] = m_s[i];
                     m_run[i] = 0;
                     if (m_s[i]) m_press[i] = 1'b1; else m_rel[i] = 1'b1;
                  end
               end
            end
         end
      end
   end

   task automatic apply_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn_in = 2'b11;
      repeat (3) begin
         @(negedge clk);
         n_vec++;
         if ({btn_deb, btn_press, btn_release, btn_long} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_hold got %b required 00000000", {btn_deb, btn_press, btn_release, btn_long});
         end
      end
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         n_vec++;
         if (dut.tick !== ((k % TD) == TD - 1)) begin
            n_bad++;
            $display("FAIL first_tick cycle %0d got %b required %b", k, dut.tick, ((k % TD) == TD - 1));
         end
         @(negedge clk);
      end
      for (int k = 0; k < 40; k++) begin
         n_vec++;
         if ({btn_deb, btn_press, btn_release, btn_long} !== 8'h00) begin
            n_bad++;
            $display("FAIL idle_zero cycle %0d got %b required 00000000", k, {btn_deb, btn_press, btn_release, btn_long});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_press();
      int np = 0, nr = 0;
      apply_reset();
      btn_in = 2'b10;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         np += btn_press[0];
         nr += btn_release[0];
         n_vec++;
         if ({btn_deb, btn_press, btn_release, btn_long} !== {m_deb, m_press, m_rel, m_long}) begin
            n_bad++;
            $display("FAIL press cycle %0d got %b required %b", k, {btn_deb, btn_press, btn_release, btn_long}, {m_deb, m_press, m_rel, m_long});
         end
      end
      n_vec++;
      if (np !== 1 || nr !== 0 || btn_deb[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL press_count got press=%0d rel=%0d deb=%b required 1 0 1", np, nr, btn_deb[0]);
      end
   endtask

   task automatic test_bounce();
      int np = 0;
      apply_reset();
      // align to tick boundaries: cycle index k has a tick when k%4==3 (pin seen 2 later)
      btn_in = 2'b10;
      for (int k = 0; k < 60; k++) begin
         if (k == 8)  btn_in = 2'b11;
         if (k == 12) btn_in = 2'b10;
         @(negedge clk);
         np += btn_press[0];
         n_vec++;
         if ({btn_deb, btn_press, btn_release, btn_long} !== {m_deb, m_press, m_rel, m_long}) begin
            n_bad++;
            $display("FAIL bounce cycle %0d got %b required %b", k, {btn_deb, btn_press, btn_release, btn_long}, {m_deb, m_press, m_rel, m_long});
         end
         if (k == 13) begin
            n_vec++;
            if (btn_deb[0] !== 1'b0) begin
               n_bad++;
               $display("FAIL bounce_early got %b required 0", btn_deb[0]);
            end
         end
      end
      n_vec++;
      if (np !== 1) begin
         n_bad++;
         $display("FAIL bounce_press_count got %0d required 1", np);
      end
   endtask

   task automatic test_long();
      int nl = 0, nr = 0, t_press = -1, t_long = -1;
      apply_reset();
      btn_in = 2'b10;
      for (int k = 0; k < 110; k++) begin
         if (k == 70) btn_in = 2'b11;
         @(negedge clk);
         if (btn_press[0] && t_press < 0) t_press = k;
         if (btn_long[0]) begin nl++; t_long = k; end
         nr += btn_release[0];
         n_vec++;
         if ({btn_deb, btn_press, btn_release, btn_long} !== {m_deb, m_press, m_rel, m_long}) begin
            n_bad++;
            $display("FAIL long cycle %0d got %b required %b", k, {btn_deb, btn_press, btn_release, btn_long}, {m_deb, m_press, m_rel, m_long});
         end
      end
      n_vec++;
      if (nl !== 1 || nr !== 1 || (t_long - t_press) !== LT * TD) begin
         n_bad++;
         $display("FAIL long_once got longs=%0d rels=%0d gap=%0d required 1 1 %0d", nl, nr, t_long - t_press, LT * TD);
      end
   endtask

   task automatic test_multi();
      int both = 0, rel1 = 0, rel0 = 0;
      apply_reset();
      btn_in = 2'b00;
      for (int k = 0; k < 80; k++) begin
         if (k == 30) btn_in = 2'b10;
         @(negedge clk);
         if (btn_press == 2'b11) both++;
         rel1 += btn_release[1];
         rel0 += btn_release[0];
         n_vec++;
         if ({btn_deb, btn_press, btn_release, btn_long} !== {m_deb, m_press, m_rel, m_long}) begin
            n_bad++;
            $display("FAIL multi cycle %0d got %b required %b", k, {btn_deb, btn_press, btn_release, btn_long}, {m_deb, m_press, m_rel, m_long});
         end
      end
      n_vec++;
      if (both !== 1 || rel1 !== 1 || rel0 !== 0) begin
         n_bad++;
         $display("FAIL multi_counts got both=%0d rel1=%0d rel0=%0d required 1 1 0", both, rel1, rel0);
      end
   endtask

   task automatic test_rst_mid();
      int np = 0, nr = 0;
      apply_reset();
      btn_in = 2'b10;
      repeat (25) @(negedge clk);
      n_vec++;
      if (btn_deb[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_pre got %b required 1", btn_deb[0]);
      end
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({btn_deb, btn_press, btn_release, btn_long} !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_mid_clear got %b required 00000000", {btn_deb, btn_press, btn_release, btn_long});
      end
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         np += btn_press[0];
         nr += btn_release[0];
         n_vec++;
         if ({btn_deb, btn_press, btn_release, btn_long} !== {m_deb, m_press, m_rel, m_long}) begin
            n_bad++;
            $display("FAIL rst_mid cycle %0d got %b required %b", k, {btn_deb, btn_press, btn_release, btn_long}, {m_deb, m_press, m_rel, m_long});
         end
      end
      n_vec++;
      if (np !== 1 || nr !== 0) begin
         n_bad++;
         $display("FAIL rst_mid_counts got press=%0d rel=%0d required 1 0", np, nr);
      end
   endtask

   task automatic test_random();
      int left [BW];
      apply_reset();
      for (int i = 0; i < BW; i++) left[i] = 0;
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < BW; i++) begin
            if (left[i] == 0) begin
               btn_in[i] = ~btn_in[i];
               left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 60);
            end else left[i]--;
         end
         rst = ($urandom_range(0, 599) == 0);
         @(negedge clk);
         n_vec++;
         if ({btn_deb, btn_press, btn_release, btn_long} !== {m_deb, m_press, m_rel, m_long}) begin
            n_bad++;
            $display("FAIL random cycle %0d got %b required %b", k, {btn_deb, btn_press, btn_release, btn_long}, {m_deb, m_press, m_rel, m_long});
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_press();
      test_bounce();
      test_long();
      test_multi();
      test_rst_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
